// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl
// Built-in self-test sequencer for a single 2-input gate.
// On an accepted start it applies the four input vectors 00, 01, 10, 11
// to the gate under test. Each vector is held for SETTLE cycles and then
// sampled for one cycle. The gate output is compared with a latched truth
// table, and per-vector mismatch flags plus a mismatch count are accumulated.
//
// Parameters
//   SETTLE    : cycles each vector is held before sampling (1..15)
// Ports
//   clk       : system clock, rising-edge
//   rst       : synchronous active-high reset
//   start     : request one run; only honoured while idle
//   truth     : expected gate output indexed by {a,b} (bit0 = 00, bit3 = 11)
//   y         : output of the gate under test
//   a, b      : drive the gate-under-test inputs
//   busy      : high while vectors are being driven/sampled
//   done      : one-cycle pulse at the end of a run
//   pass      : result of last completed run (1 = no mismatches)
//   err_count : mismatch count of current/last run
//   fail_vec  : per-vector mismatch flags, same indexing as truth
module gate_bist_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] truth,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    // Last value of the settle counter before moving on to SAMPLE.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] truth_q, truth_n;
    logic       a_n, b_n, busy_n, done_n, pass_n;
    logic [2:0] err_n;
    logic [3:0] fail_n;

    // Next-state and next-output logic. Every output is produced here as a
    // next value and then registered, so a, b, busy and done change on
    // the same edge as the state they describe.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        truth_n = truth_q;
        a_n     = a;
        b_n     = b;
        pass_n  = pass;
        err_n   = err_count;
        fail_n  = fail_vec;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = DRIVE;
                    truth_n = truth;
                    err_n   = 3'd0;
                    fail_n  = 4'd0;
                    idx_n   = 2'd0;
                    cnt_n   = 4'd0;
                    pass_n  = 1'b0;
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                end
            end

            DRIVE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = SAMPLE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end

            SAMPLE: begin
                if (y != truth_q[idx]) begin
                    err_n       = err_count + 3'd1;
                    fail_n[idx] = 1'b1;
                end
                if (idx == 2'd3) begin
                    // The verdict must include this final compare, so it
                    // is taken from the updated count rather than err_count.
                    state_n = DONE;
                    pass_n  = (err_n == 3'd0);
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                end else begin
                    state_n    = DRIVE;
                    idx_n      = idx + 2'd1;
                    {a_n, b_n} = idx + 2'd1;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == DRIVE) || (state_n == SAMPLE);
        done_n = (state_n == DONE);
    end

    // State and output registers. Reset wins over everything, including a
    // run in progress, and never produces a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            truth_q   <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            truth_q   <= truth_n;
            a         <= a_n;
            b         <= b_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_count <= err_n;
            fail_vec  <= fail_n;
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl
// Self-checking bench for gate_bist_ctrl. Two instances are built, one with
// SETTLE=1 and one with SETTLE=3, each driving its own modelled gate.
// Expected timing and results come from the run arithmetic: vector k
// occupies cycles k*(S+1)+1 .. (k+1)*(S+1) after the accepting edge, and
// done follows in the next cycle. The mismatch flags are obtained by
// comparing the modelled gate against the truth table presented at start.
module tb_gate_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] truth = 4'd0;

    logic       y1, a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fv1;
    logic       y3, a3, b3, busy3, done3, pass3;
    logic [2:0] err3;
    logic [3:0] fv3;

    int         total = 0;
    int         bad = 0;
    int         gate_mode = 0;
    logic [3:0] rand_tab = 4'd0;
    int         sel = 1;

    logic [3:0] o_ctl;
    logic       o_pass;
    logic [2:0] o_err;
    logic [3:0] o_fv;

    always #5 clk = ~clk;

    gate_bist_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .truth(truth), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    gate_bist_ctrl #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .truth(truth), .y(y3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_vec(fv3)
    );

    // Gate under test: 0 = XNOR, 1 = stuck at 0, otherwise a lookup table.
    function automatic logic gate_fn(input int mode, input logic [1:0] v,
                                     input logic [3:0] tab);
        case (mode)
            0:       return ~(v[1] ^ v[0]);
            1:       return 1'b0;
            default: return tab[v];
        endcase
    endfunction

    always_comb y1 = gate_fn(gate_mode, {a1, b1}, rand_tab);
    always_comb y3 = gate_fn(gate_mode, {a3, b3}, rand_tab);

    // Observed outputs of whichever instance the current test looks at.
    always_comb begin
        if (sel == 3) begin
            o_ctl  = {a3, b3, busy3, done3};
            o_pass = pass3;
            o_err  = err3;
            o_fv   = fv3;
        end else begin
            o_ctl  = {a1, b1, busy1, done1};
            o_pass = pass1;
            o_err  = err1;
            o_fv   = fv1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        start = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // One complete run on the selected instance, starting from an idle cycle
    // and ending in the idle cycle that follows done.
    task automatic do_run(input int s, input logic [3:0] tv, input bit hold,
                          input bit spam, input bit scramble, input string tag);
        int         run_len;
        int         exp_err;
        logic [3:0] exp_fv;
        logic [3:0] exp_ctl;
        int         idx;
        run_len = 4 * (s + 1);
        exp_fv  = 4'd0;
        for (int v = 0; v < 4; v++)
            if (gate_fn(gate_mode, 2'(v), rand_tab) !== tv[v]) exp_fv[v] = 1'b1;
        exp_err = $countones(exp_fv);

        truth = tv;
        start = 1'b1;
        next_cycle();
        if (!hold) start = 1'b0;
        if (scramble) truth = 4'($urandom);

        for (int c = 1; c <= run_len; c++) begin
            idx     = (c - 1) / (s + 1);
            exp_ctl = {2'(idx), 2'b10};
            total++;
            if (o_ctl !== exp_ctl) begin
                bad++;
                $display("[TB] FAIL %s cycle %0d {a,b,busy,done}: got %b want %b",
                         tag, c, o_ctl, exp_ctl);
            end
            if (spam) start = 1'($urandom);
            next_cycle();
        end
        start = hold;

        total++;
        if (o_ctl !== 4'b0001 || o_err !== 3'(exp_err) || o_fv !== exp_fv ||
            o_pass !== (exp_err == 0)) begin
            bad++;
            $display("[TB] FAIL %s done-cycle ctl/err/fv/pass: got %b/%0d/%b/%b want 0001/%0d/%b/%b",
                     tag, o_ctl, o_err, o_fv, o_pass, exp_err, exp_fv, exp_err == 0);
        end
        next_cycle();

        total++;
        if (o_ctl !== 4'b0000 || o_err !== 3'(exp_err) || o_fv !== exp_fv ||
            o_pass !== (exp_err == 0)) begin
            bad++;
            $display("[TB] FAIL %s idle-hold ctl/err/fv/pass: got %b/%0d/%b/%b want 0000/%0d/%b/%b",
                     tag, o_ctl, o_err, o_fv, o_pass, exp_err, exp_fv, exp_err == 0);
        end
    endtask

    task automatic test_reset();
        truth = 4'($urandom);
        start = 1'b1;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            total++;
            if ({a1, b1, busy1, done1, pass1, err1, fv1} !== 12'd0 ||
                {a3, b3, busy3, done3, pass3, err3, fv3} !== 12'd0) begin
                bad++;
                $display("[TB] FAIL reset outputs: got %b / %b want all zero",
                         {a1, b1, busy1, done1, pass1, err1, fv1},
                         {a3, b3, busy3, done3, pass3, err3, fv3});
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        next_cycle();
    endtask

    task automatic test_xnor_pass();
        apply_reset();
        sel = 1; gate_mode = 0;
        do_run(1, 4'b1001, 1'b0, 1'b0, 1'b0, "xnor_pass");
    endtask

    task automatic test_xor_table();
        apply_reset();
        sel = 1; gate_mode = 0;
        do_run(1, 4'b0110, 1'b0, 1'b0, 1'b0, "xor_table");
    endtask

    task automatic test_stuck_low();
        apply_reset();
        sel = 1; gate_mode = 1;
        do_run(1, 4'b1001, 1'b0, 1'b0, 1'b0, "stuck_low");
    endtask

    task automatic test_slow_settle();
        apply_reset();
        sel = 3; gate_mode = 0;
        do_run(3, 4'b1001, 1'b0, 1'b1, 1'b0, "slow_settle");
    endtask

    task automatic test_abort();
        apply_reset();
        sel = 1; gate_mode = 0;
        do_run(1, 4'b1001, 1'b0, 1'b0, 1'b0, "abort_pre");
        gate_mode = 1;
        truth = 4'b1001;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) next_cycle();
        total++;
        if (o_ctl !== 4'b1010 || o_err !== 3'd1) begin
            bad++;
            $display("[TB] FAIL abort vec2-sample ctl/err: got %b/%0d want 1010/1", o_ctl, o_err);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        total++;
        if (o_ctl !== 4'b0000 || o_err !== 3'd0 || o_fv !== 4'd0 || o_pass !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort reset ctl/err/fv/pass: got %b/%0d/%b/%b want 0000/0/0000/0",
                     o_ctl, o_err, o_fv, o_pass);
        end
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            total++;
            if (o_ctl !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL abort quiet cycle %0d ctl: got %b want 0000", i, o_ctl);
            end
        end
        gate_mode = 0;
        do_run(1, 4'b1001, 1'b0, 1'b0, 1'b0, "abort_rerun");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        sel = 1; gate_mode = 0;
        do_run(1, 4'b1001, 1'b1, 1'b0, 1'b1, "b2b_run1");
        do_run(1, 4'b0110, 1'b1, 1'b0, 1'b1, "b2b_run2");
        do_run(1, 4'b1001, 1'b0, 1'b0, 1'b1, "b2b_run3");
        start = 1'b0;
    endtask

    task automatic test_random();
        int s;
        gate_mode = 2;
        for (int it = 0; it < 6; it++) begin
            apply_reset();
            rand_tab = 4'($urandom);
            s        = ($urandom_range(0, 1) == 0) ? 1 : 3;
            sel      = s;
            do_run(s, 4'($urandom), 1'b0, 1'($urandom), 1'b1, "random");
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_xnor_pass();
        test_xor_table();
        test_stuck_low();
        test_slow_settle();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning cycles each input vector is held before the output is sampled (legal 1..15).
REQ-002 The block SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request one self-test run; accepted only in IDLE.
REQ-005 The block SHALL have port truth  input  4  expected gate output per vector, indexed by {a,b} (bit0 = 00, bit3 = 11).
REQ-006 The block SHALL have port y  input  1  output of the 2-input gate under test.
REQ-007 The block SHALL have ports a and b, each output 1, driving the gate-under-test inputs.
REQ-008 The block SHALL have port busy  output  1  high while a run is in progress (DRIVE or SAMPLE).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-010 The block SHALL have port pass  output  1  result of last completed run, 1 = no mismatches.
REQ-011 The block SHALL have port err_count  output  3  mismatch count of current/last run (0..4).
REQ-012 The block SHALL have port fail_vec  output  4  per-vector mismatch flags, same indexing as truth.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE; all outputs SHALL be registered.
REQ-014 In IDLE, start=1 at a rising edge SHALL latch truth, clear err_count and fail_vec, set vector index to 0 and enter DRIVE.
REQ-015 In DRIVE, {a,b} SHALL equal the 2-bit vector index; the FSM SHALL stay SETTLE cycles, then enter SAMPLE.
REQ-016 In SAMPLE, {a,b} SHALL hold; at the edge leaving SAMPLE, y SHALL be compared with latched truth[index].
REQ-017 On mismatch, err_count SHALL increment by 1 and fail_vec[index] SHALL be set; on match, neither SHALL change.
REQ-018 After SAMPLE, index 0..2 SHALL increment and return to DRIVE; index 3 SHALL enter DONE (no wrap to 0).
REQ-019 Vectors SHALL be applied in order 00, 01, 10, 11; each SHALL occupy exactly SETTLE+1 cycles.
REQ-020 done SHALL be high exactly during DONE, i.e. the cycle after the 4*(SETTLE+1)-th rising edge following the start edge.
REQ-021 On DONE entry, pass SHALL be set to (final err_count == 0), including the vector-3 compare; pass SHALL hold until the next accepted start.
REQ-022 DONE SHALL last one cycle, then go to IDLE; a,b SHALL return to 0 in IDLE.
REQ-023 start SHALL be ignored in DRIVE, SAMPLE and DONE; a start held through DONE SHALL be accepted on the first IDLE cycle.
REQ-024 Changes on truth after the accepting edge SHALL NOT affect the run in progress.
REQ-025 busy SHALL be 1 in DRIVE and SAMPLE, 0 in IDLE and DONE.
REQ-026 err_count and fail_vec SHALL hold their final values after DONE until the next accepted start.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, index=0 and the settle counter to 0.
REQ-028 rst SHALL take priority over start and SHALL abort a run in any state with no done pulse.

Verification
REQ-029 XNOR gate attached, truth=4'b1001, SETTLE=1, start pulse -> a,b step 00,01,10,11 every 2 cycles; done at 8 edges after start; pass=1, err_count=0, fail_vec=0000.
REQ-030 XNOR gate attached, truth=4'b0110 (XOR table) -> pass=0, err_count=4, fail_vec=1111.
REQ-031 y tied to 0, truth=4'b1001 -> err_count=2, fail_vec=1001, pass=0.
REQ-032 SETTLE=3, correct gate -> each vector held 4 cycles; done 16 edges after start; start pulses during run ignored; busy=1 throughout.
REQ-033 rst asserted while in SAMPLE of vector 2 -> next cycle all outputs at reset values, no done pulse; a following start runs a full clean pass.
REQ-034 start held high continuously -> back-to-back runs with one IDLE cycle between; truth changed mid-run has no effect on that run.
